// File: rtl/pc_fetch_unit.sv
// Sequential instruction fetch front-end: one outstanding imem request, registered instruction to decode.
// Optional macro FETCH_MISALIGN_TRAP_EN traps misaligned retire targets into a sticky FAULT state.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_four,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] fetch_count,
  output logic        misalign_fault
);

  // state | meaning
  // REQ   | request presented at pc, waiting for imem_req_ready
  // WAIT  | request accepted, waiting for imem_rsp_valid
  // HOLD  | instruction presented to decode, waiting for instr_ready
  // FAULT | misaligned retire target trapped; only reset leaves
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        retire;
  logic        misaligned;

  assign retire = (state_q == S_HOLD) && instr_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  assign misaligned = (pc_next[1:0] != 2'b00);
  assign fault_d    = fault_q | (retire & misaligned);

  always_ff @(posedge clk) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  assign misalign_fault = fault_q;
`else
  assign misaligned     = 1'b0;
  assign misalign_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_VECTOR;
      instr_q       <= 32'h0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ:   if (imem_req_ready) state_d = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_d = S_HOLD;
      S_HOLD:  if (instr_ready)    state_d = misaligned ? S_FAULT : S_REQ;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    fetch_count_d = fetch_count_q;
    if ((state_q == S_WAIT) && imem_rsp_valid) instr_d = imem_rdata;
    if (retire) begin
      fetch_count_d = fetch_count_q + 32'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (!misaligned) pc_d = pc_next;
`else
      // Low bits are dropped so fetch addresses are always word aligned.
      pc_d = pc_next & ~32'h3;
`endif
    end
  end

  always_comb begin
    imem_req_valid = (state_q == S_REQ);
    instr_valid    = (state_q == S_HOLD);
  end

  assign pc           = pc_q;
  assign imem_addr    = pc_q;
  assign pc_plus_four = pc_q + 32'd4;
  assign instr        = instr_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a driver plays memory and decode, a negedge monitor checks
// every presented request/instruction against an abstract model of pc, count and fault.
module tb_pc_fetch_unit;
  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic [31:0] pc_plus_four;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] fetch_count;
  logic        misalign_fault;

  pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_next       (pc_next),
    .pc            (pc),
    .pc_plus_four  (pc_plus_four),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .fetch_count   (fetch_count),
    .misalign_fault(misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  logic [31:0] req_q[$];
  exp_t        rsp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [31:0] model_pc;
  logic [31:0] model_count;
  logic        model_fault;
  int          waits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the head of the expectation queues.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("misalign_fault", {31'h0, misalign_fault}, {31'h0, model_fault});
      if (imem_req_valid) begin
        if (req_q.size() == 0) chk("spurious_req", 32'h1, 32'h0);
        else begin
          chk("imem_addr", imem_addr, req_q[0]);
          chk("pc_in_req", pc, req_q[0]);
          chk("pc_plus_four_req", pc_plus_four, req_q[0] + 32'd4);
          if (imem_req_ready) void'(req_q.pop_front());
        end
      end
      if (instr_valid) begin
        if (rsp_q.size() == 0) chk("spurious_instr_valid", 32'h1, 32'h0);
        else begin
          chk("instr", instr, rsp_q[0].instr);
          chk("pc_in_hold", pc, rsp_q[0].pc);
          chk("pc_plus_four_hold", pc_plus_four, rsp_q[0].pc + 32'd4);
          if (instr_ready) begin
            chk("fetch_count", fetch_count, rsp_q[0].cnt);
            void'(rsp_q.pop_front());
          end
        end
      end
    end
  end

  // One full instruction: request backpressure, response delay, decode backpressure, retire.
  task automatic txn(input int rdy_dly, input int rsp_dly, input int ret_dly,
                     input logic [31:0] data, input logic [31:0] nxt, input bit preload);
    int w;
    req_q.push_back(model_pc);
    repeat (rdy_dly) begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rdata     = $urandom;
      instr_ready    = 1'($urandom_range(0, 1));
      pc_next        = $urandom;
      step();
    end
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    w = 0;
    @(negedge clk);
    while (!imem_req_valid && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (w >= 50) chk("timeout_req", 32'h0, 32'h1);
    waits += w;
    step();
    imem_req_ready = 1'b0;
    repeat (rsp_dly) begin
      imem_rsp_valid = 1'b0;
      imem_rdata     = $urandom;
      instr_ready    = 1'($urandom_range(0, 1));
      pc_next        = $urandom;
      step();
    end
    rsp_q.push_back('{data, model_pc, model_count});
    imem_rsp_valid = 1'b1;
    imem_rdata     = data;
    instr_ready    = 1'b0;
    step();
    if (preload) begin
      force dut.fetch_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_count_q;
      model_count   = 32'hFFFF_FFFF;
      rsp_q[0].cnt  = 32'hFFFF_FFFF;
    end
    repeat (ret_dly) begin
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rdata     = $urandom;
      instr_ready    = 1'b0;
      pc_next        = $urandom;
      step();
    end
    imem_rsp_valid = 1'($urandom_range(0, 1));
    imem_rdata     = $urandom;
    instr_ready    = 1'b1;
    pc_next        = nxt;
    w = 0;
    @(negedge clk);
    while (!instr_valid && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (w >= 50) chk("timeout_hold", 32'h0, 32'h1);
    waits += w;
    step();
    instr_ready    = 1'b0;
    imem_rsp_valid = 1'b0;
    model_count    = model_count + 32'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (nxt % 4 != 0) model_fault = 1'b1;
    else              model_pc    = nxt;
`else
    model_pc = nxt - (nxt % 4);
`endif
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
    t = t - (t % 4);
`endif
    return t;
  endfunction

  initial begin
    rst_n = 1'b0; pc_next = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rdata = '0; instr_ready = 1'b0;
    model_pc = RV; model_count = '0; model_fault = 1'b0; waits = 0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_pc", pc, RV);
    chk("rst_instr", instr, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_fault", {31'h0, misalign_fault}, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    step();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    txn(0, 0, 0, 32'h0050_0093, 32'h0000_0104, 1'b0);
    chk("min_latency_waits", waits, 0);
    txn(4, 3, 5, 32'hDEAD_BEEF, 32'h0000_0080, 1'b0);
    txn(2, 1, 2, 32'h1234_5678, 32'hFFFF_FFFC, 1'b0);
    txn(1, 0, 1, 32'h0BAD_F00D, 32'h0000_0200, 1'b1);
    txn(0, 2, 0, 32'hCAFE_0001, 32'h0000_0300, 1'b0);
    for (int i = 0; i < 40; i++)
      txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, rand_target(), 1'b0);

    // Reset while a request is outstanding; the late response must be ignored.
    req_q.push_back(model_pc);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    step();
    req_q.delete();
    rsp_q.delete();
    model_pc = RV; model_count = '0; model_fault = 1'b0;
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'h5555_AAAA;
    @(negedge clk);
    chk("midrst_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("midrst_addr", imem_addr, RV);
    chk("midrst_count", fetch_count, 32'h0);
    step();
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("late_rsp_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("late_rsp_instr", instr, 32'h0);
    chk("late_rsp_pc", pc, RV);
    step();
    mon_en = 1'b1;

    txn(1, 1, 1, 32'h0000_0013, 32'h0000_0100, 1'b0);
    txn(0, 0, 0, 32'h0000_0033, 32'h0000_0102, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    repeat (6) begin
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'($urandom_range(0, 1));
      instr_ready    = 1'($urandom_range(0, 1));
      pc_next        = $urandom;
      @(negedge clk);
      chk("fault_no_req", {31'h0, imem_req_valid}, 32'h0);
      chk("fault_pc", pc, 32'h0000_0100);
      chk("fault_count", fetch_count, model_count);
      step();
    end
`else
    chk("misalign_pc_aligned", model_pc, 32'h0000_0100);
    txn(0, 1, 0, 32'h0000_0073, 32'h0000_0104, 1'b0);
`endif
    mon_en = 1'b0;
    @(negedge clk);
    chk("final_count", fetch_count, model_count);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
